// File: rtl/acc_sram_pkg.sv
// Shared definitions for the accelerator SRAM buffer path.
// Holds SRAM geometry defaults and the read-streamer state encoding.
package acc_sram_pkg;

    // Defaults matching the 4Kx64 sram_top macro wrapper.
    localparam int SRAM_DW = 64;
    localparam int SRAM_MW = SRAM_DW / 8;
    localparam int SRAM_AW = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock DW x FD FIFO, shared by the read- and write-side stages.
// Ports: push/push_data in, pop in, pop_data = head (0 when empty),
// full, empty, count (occupancy). Push while full is taken only with a pop.
module sync_fifo #(
    parameter  int DW = 64,
    parameter  int FD = 4,
    localparam int PW = $clog2(FD),
    localparam int CW = $clog2(FD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] mem_q [FD];
    logic          do_push;
    logic          do_pop;

    always_comb begin
        full    = (count_q == CW'(FD));
        empty   = (count_q == '0);
        count   = count_q;
        do_pop  = pop && !empty;
        // A full FIFO still accepts a push when the head leaves this cycle.
        do_push = push && (!full || do_pop);
        // Head is forced to 0 when empty so the output is clean after reset.
        pop_data = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only observed through a non-empty head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/sram_rd_streamer.sv
// Burst reader behind sram_top: issues single-word reads, absorbs the
// 1-cycle SRAM latency and streams words out through a small FIFO.
// Ports: start/base_addr/len command, busy/done status, sram_* macro
// interface (read-only), m_valid/m_ready/m_data output stream.
module sram_rd_streamer
    import acc_sram_pkg::*;
#(
    parameter int DW = SRAM_DW,
    parameter int MW = SRAM_MW,
    parameter int AW = SRAM_AW,
    parameter int FD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [MW-1:0] sram_wem,
    output logic [AW-1:0] sram_addr,
    input  logic [DW-1:0] sram_dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
);

    localparam int CW = $clog2(FD + 1);

    rd_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   issued_q, issued_d;
    logic [AW:0]   popped_q, popped_d;
    logic          inflight_q, inflight_d;
    logic          done_q, done_d;

    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          m_pop;
    logic [CW:0]   occ;
    logic          room;
    logic          can_issue;
    logic          last_issue;
    logic          last_pop;
    logic          start_ok;
    logic          start_zero;

    // Read data lands one cycle after the issue; push it unconditionally,
    // a slot was reserved when the read went out.
    assign fifo_push = inflight_q;

    sync_fifo #(
        .DW(DW),
        .FD(FD)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(sram_dout),
        .pop      (m_pop),
        .pop_data (m_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Issue / handshake status shared by the FSM and datapath.
    always_comb begin
        m_valid = !fifo_empty;
        m_pop   = m_valid && m_ready;
        // Occupancy counts words stored plus reads in flight; a pop this
        // cycle is also counted, which keeps the reservation conservative.
        occ = (CW+1)'(fifo_count)
            + (CW+1)'(inflight_q)
            + (CW+1)'(m_pop);
        room       = (occ < (CW+1)'(FD));
        can_issue  = (state_q == ST_RUN)
                  && (issued_q < len_q)
                  && room;
        last_issue = can_issue
                  && ((issued_q + (AW+1)'(1)) == len_q);
        last_pop   = m_pop
                  && ((popped_q + (AW+1)'(1)) == len_q);
        start_ok   = (state_q == ST_IDLE) && start
                  && (len != '0);
        start_zero = (state_q == ST_IDLE) && start
                  && (len == '0);
    end

    // FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_pop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = done_q;
        sram_cs   = can_issue;
        sram_we   = 1'b0;
        sram_wem  = '0;
        sram_addr = addr_q;
    end

    // Datapath next values.
    always_comb begin
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        popped_d   = popped_q;
        inflight_d = can_issue;
        done_d     = 1'b0;
        if (start_ok) begin
            addr_d   = base_addr;
            len_d    = len;
            issued_d = '0;
            popped_d = '0;
        end
        if (start_zero) begin
            done_d = 1'b1;
        end
        if (can_issue) begin
            // AW-bit add wraps 4095 -> 0 on its own.
            addr_d   = addr_q + AW'(1);
            issued_d = issued_q + (AW+1)'(1);
        end
        if (m_pop && (state_q != ST_IDLE)) begin
            popped_d = popped_q + (AW+1)'(1);
        end
        if ((state_q == ST_DRAIN) && last_pop) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Directed self-checking bench for sram_rd_streamer with a 1-cycle
// SRAM model preloaded with data 0x1000 + address.
module tb_sram_rd_streamer;

    localparam int DW = 64;
    localparam int MW = 8;
    localparam int AW = 12;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;
    logic          sram_cs;
    logic          sram_we;
    logic [MW-1:0] sram_wem;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dout = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;

    int n_chk  = 0;
    int n_pass = 0;

    sram_rd_streamer #(
        .DW(DW), .MW(MW), .AW(AW), .FD(FD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .sram_cs  (sram_cs),
        .sram_we  (sram_we),
        .sram_wem (sram_wem),
        .sram_addr(sram_addr),
        .sram_dout(sram_dout),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data)
    );

    always #5 clk = ~clk;

    // SRAM macro model: read data valid one cycle after cs.
    logic [DW-1:0] mem [4096];
    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 64'h1000 + 64'(a);
    end
    always @(posedge clk) begin
        if (sram_cs && !sram_we) sram_dout <= mem[sram_addr];
    end

    // Monitor, sampled on the falling edge.
    bit            mon_clr = 1'b0;
    int            cyc = 0;
    bit            start_seen;
    int            start_cyc;
    logic [DW-1:0] rx_q [$];
    int            rx_cyc [$];
    logic [AW-1:0] ad_q [$];
    int            done_cnt;
    int            done_cyc;
    bit            busy_seen;
    int            max_cnt;
    bit            ovf;
    bit            stall_err;
    bit            prev_stall;
    logic [DW-1:0] prev_data;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (mon_clr) begin
            rx_q.delete();
            rx_cyc.delete();
            ad_q.delete();
            start_seen = 0;
            start_cyc  = 0;
            done_cnt   = 0;
            done_cyc   = 0;
            busy_seen  = 0;
            max_cnt    = 0;
            ovf        = 0;
            stall_err  = 0;
            prev_stall = 0;
        end else begin
            if (start && !start_seen) begin
                start_seen = 1;
                start_cyc  = cyc;
            end
            if (m_valid && m_ready) begin
                rx_q.push_back(m_data);
                rx_cyc.push_back(cyc);
            end
            if (sram_cs) ad_q.push_back(sram_addr);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_seen = 1;
            if (int'(dut.fifo_count) > max_cnt)
                max_cnt = int'(dut.fifo_count);
            if (dut.fifo_push && dut.fifo_full && !dut.m_pop)
                ovf = 1;
            if (prev_stall && m_data !== prev_data)
                stall_err = 1;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // m_ready pattern 1,0,0,1 when rdy_mode is set.
    bit       rdy_mode = 0;
    logic [3:0] pat = 4'b1001;
    int       pat_i = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        pat_i = (pat_i + 1) % 4;
        m_ready = rdy_mode ? pat[pat_i] : 1'b1;
    endtask

    task automatic clear_mon();
        mon_clr = 1;
        tick();
        mon_clr = 0;
    endtask

    task automatic go(input logic [AW-1:0] b, input logic [AW:0] l);
        start     = 1;
        base_addr = b;
        len       = l;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input int lim, input string nm);
        bit ok = 0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (done) begin
                ok = 1;
                break;
            end
        end
        n_chk++;
        if (!ok) $display("FAIL %s_timeout: done not seen in %0d cycles", nm, lim);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        n_chk++;
        if ({busy, done, sram_cs, m_valid} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000",
                     {busy, done, sram_cs, m_valid});
        else n_pass++;
        n_chk++;
        if (sram_addr !== '0)
            $display("FAIL reset_addr: got %h want 000", sram_addr);
        else n_pass++;
        n_chk++;
        if (m_data !== '0)
            $display("FAIL reset_mdata: got %h want 0", m_data);
        else n_pass++;
        rst = 0;
        tick();
    endtask

    task automatic test_basic();
        clear_mon();
        go(12'h010, 13'd8);
        wait_done(50, "basic");
        tick(); tick(); tick();
        n_chk++;
        if (rx_q.size() !== 8)
            $display("FAIL basic_count: got %0d want 8", rx_q.size());
        else n_pass++;
        for (int i = 0; i < rx_q.size() && i < 8; i++) begin
            n_chk++;
            if (rx_q[i] !== 64'h1010 + 64'(i))
                $display("FAIL basic_data[%0d]: got %h want %h",
                         i, rx_q[i], 64'h1010 + 64'(i));
            else n_pass++;
        end
        if (rx_q.size() == 8) begin
            n_chk++;
            if (rx_cyc[0] - start_cyc !== 3)
                $display("FAIL basic_latency: got %0d want 3",
                         rx_cyc[0] - start_cyc);
            else n_pass++;
            n_chk++;
            if (rx_cyc[7] - rx_cyc[0] !== 7)
                $display("FAIL basic_rate: got %0d want 7",
                         rx_cyc[7] - rx_cyc[0]);
            else n_pass++;
            n_chk++;
            if (done_cyc !== rx_cyc[7] + 1)
                $display("FAIL basic_done_cyc: got %0d want %0d",
                         done_cyc, rx_cyc[7] + 1);
            else n_pass++;
        end
        n_chk++;
        if (done_cnt !== 1)
            $display("FAIL basic_done_cnt: got %0d want 1", done_cnt);
        else n_pass++;
        n_chk++;
        if (ad_q.size() !== 8)
            $display("FAIL basic_cs_cycles: got %0d want 8", ad_q.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        clear_mon();
        rdy_mode = 1;
        go(12'h010, 13'd8);
        wait_done(200, "bp");
        rdy_mode = 0;
        tick(); tick(); tick();
        n_chk++;
        if (rx_q.size() !== 8)
            $display("FAIL bp_count: got %0d want 8", rx_q.size());
        else n_pass++;
        for (int i = 0; i < rx_q.size() && i < 8; i++) begin
            n_chk++;
            if (rx_q[i] !== 64'h1010 + 64'(i))
                $display("FAIL bp_data[%0d]: got %h want %h",
                         i, rx_q[i], 64'h1010 + 64'(i));
            else n_pass++;
        end
        n_chk++;
        if (stall_err !== 1'b0)
            $display("FAIL bp_stable: m_data changed during stall");
        else n_pass++;
        n_chk++;
        if (max_cnt > FD)
            $display("FAIL bp_fifo_max: got %0d want <= %0d", max_cnt, FD);
        else n_pass++;
        n_chk++;
        if (ovf !== 1'b0)
            $display("FAIL bp_overflow: push into full FIFO without pop");
        else n_pass++;
        n_chk++;
        if (done_cnt !== 1)
            $display("FAIL bp_done_cnt: got %0d want 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea [4];
        logic [DW-1:0] ed [4];
        ea = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        ed = '{64'h1FFE, 64'h1FFF, 64'h1000, 64'h1001};
        clear_mon();
        go(12'hFFE, 13'd4);
        wait_done(50, "wrap");
        tick(); tick();
        n_chk++;
        if (ad_q.size() !== 4 || rx_q.size() !== 4)
            $display("FAIL wrap_count: got addr %0d data %0d want 4 4",
                     ad_q.size(), rx_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < ad_q.size() && i < rx_q.size(); i++) begin
            n_chk++;
            if (ad_q[i] !== ea[i] || rx_q[i] !== ed[i])
                $display("FAIL wrap[%0d]: got %h/%h want %h/%h",
                         i, ad_q[i], rx_q[i], ea[i], ed[i]);
            else n_pass++;
        end
    endtask

    task automatic test_zero_len();
        clear_mon();
        go(12'h055, 13'd0);
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL zero_done: got done=%b busy=%b want 1 0",
                     done, busy);
        else n_pass++;
        tick(); tick(); tick();
        n_chk++;
        if (done_cnt !== 1 || busy_seen !== 1'b0 || ad_q.size() !== 0)
            $display("FAIL zero_side: got done_cnt=%0d busy=%b cs=%0d want 1 0 0",
                     done_cnt, busy_seen, ad_q.size());
        else n_pass++;
    endtask

    task automatic test_max_len();
        int bad = 0;
        clear_mon();
        go(12'h000, 13'h1000);
        wait_done(4300, "max");
        tick(); tick(); tick();
        n_chk++;
        if (rx_q.size() !== 4096)
            $display("FAIL max_count: got %0d want 4096", rx_q.size());
        else n_pass++;
        for (int i = 0; i < rx_q.size(); i++)
            if (rx_q[i] !== 64'h1000 + 64'(i)) bad++;
        n_chk++;
        if (bad !== 0)
            $display("FAIL max_data: got %0d bad words want 0", bad);
        else n_pass++;
        n_chk++;
        if (done_cnt !== 1 || ad_q.size() !== 4096)
            $display("FAIL max_done: got done=%0d cs=%0d want 1 4096",
                     done_cnt, ad_q.size());
        else n_pass++;
        if (rx_q.size() == 4096) begin
            n_chk++;
            if (rx_cyc[4095] - rx_cyc[0] !== 4095)
                $display("FAIL max_rate: got %0d want 4095",
                         rx_cyc[4095] - rx_cyc[0]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        go(12'h010, 13'd8);
        tick(); tick(); tick();
        // Ignored: burst is running.
        go(12'h100, 13'd3);
        wait_done(50, "b2b_first");
        // Coincident with done: accepted.
        go(12'h200, 13'd2);
        wait_done(50, "b2b_second");
        tick(); tick(); tick();
        n_chk++;
        if (rx_q.size() !== 10)
            $display("FAIL b2b_count: got %0d want 10", rx_q.size());
        else n_pass++;
        for (int i = 0; i < rx_q.size() && i < 8; i++) begin
            n_chk++;
            if (rx_q[i] !== 64'h1010 + 64'(i))
                $display("FAIL b2b_data[%0d]: got %h want %h",
                         i, rx_q[i], 64'h1010 + 64'(i));
            else n_pass++;
        end
        if (rx_q.size() == 10) begin
            n_chk++;
            if (rx_q[8] !== 64'h1200 || rx_q[9] !== 64'h1201)
                $display("FAIL b2b_second: got %h %h want 1200 1201",
                         rx_q[8], rx_q[9]);
            else n_pass++;
        end
        n_chk++;
        if (done_cnt !== 2 || ad_q.size() !== 10)
            $display("FAIL b2b_done: got done=%0d cs=%0d want 2 10",
                     done_cnt, ad_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        bit hit = 0;
        clear_mon();
        go(12'h030, 13'd8);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rx_q.size() >= 3) begin
                hit = 1;
                break;
            end
        end
        n_chk++;
        if (!hit) $display("FAIL rstmid_timeout: 3 words not seen");
        else n_pass++;
        rst = 1;
        #1;
        n_chk++;
        if ({m_valid, busy, sram_cs} !== 3'b000)
            $display("FAIL rstmid_flags: got %b want 000",
                     {m_valid, busy, sram_cs});
        else n_pass++;
        tick(); tick();
        rst = 0;
        tick(); tick(); tick();
        n_chk++;
        if (done_cnt !== 0)
            $display("FAIL rstmid_no_done: got %0d want 0", done_cnt);
        else n_pass++;
        clear_mon();
        go(12'h040, 13'd4);
        wait_done(50, "rstmid_fresh");
        tick(); tick();
        n_chk++;
        if (rx_q.size() !== 4 || done_cnt !== 1)
            $display("FAIL rstmid_fresh: got words=%0d done=%0d want 4 1",
                     rx_q.size(), done_cnt);
        else n_pass++;
        for (int i = 0; i < rx_q.size() && i < 4; i++) begin
            n_chk++;
            if (rx_q[i] !== 64'h1040 + 64'(i))
                $display("FAIL rstmid_data[%0d]: got %h want %h",
                         i, rx_q[i], 64'h1040 + 64'(i));
            else n_pass++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_max_len();
        test_back_to_back();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_rd_streamer.md
Name: sram_rd_streamer

Overview:
- Read-side stage directly downstream of the 4Kx64 SRAM wrapper (sram_top) in the accelerator buffer path.
- Takes a burst command (base address, word count), issues single-word reads to the SRAM macro, and absorbs its 1-cycle read latency.
- Presents the words in order on a valid/ready stream to the compute array, with a small internal FIFO so backpressure never loses a word.

Parameters:
- DW, 64, SRAM data width in bits.
- MW, 8, SRAM byte-mask width (DW/8).
- AW, 12, SRAM word address width.
- FD, 4, output FIFO depth in words; power of two, at least 2.

Ports:
- clk  in  1  clock, all state rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle burst request; accepted only in IDLE.
- base_addr  in  AW  first word address of the burst.
- len  in  AW+1  number of words, 0..2^AW.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last word is handed off.
- sram_cs  out  1  SRAM chip select, drives sram_top cs.
- sram_we  out  1  SRAM write enable; tied 0.
- sram_wem  out  MW  SRAM byte mask; tied 0.
- sram_addr  out  AW  SRAM word address.
- sram_dout  in  DW  SRAM read data, valid 1 cycle after cs.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer ready.
- m_data  out  DW  output word (FIFO head).

Behaviour:
- Reset values: busy=0, done=0, sram_cs=0, sram_addr=0, m_valid=0, FIFO empty, m_data=0. State is IDLE.
- Reset asserted mid-burst aborts the burst immediately: no done pulse, and the FIFO and in-flight state are cleared.
- State IDLE:
  - start=1 with len>0: latch base_addr and len, move to RUN, busy=1 from the next cycle.
  - start=1 with len=0: done=1 the next cycle, busy stays 0, no SRAM access.
- State RUN: each cycle, sram_cs=1 with sram_addr=current address iff both hold:
  - issued < len;
  - fifo_count + inflight + (1 if pop this cycle, else 0) < FD, i.e. a FIFO slot is reserved for every outstanding read.
- Issue bookkeeping:
  - Each issue sets an inflight flag for one cycle.
  - The next cycle, sram_dout is pushed into the FIFO.
  - The address increments modulo 2^AW, so a burst crossing 4095 wraps to 0.
- When all len words are issued, move to DRAIN. In DRAIN, sram_cs=0.
- State DRAIN: when popped == len (the last word accepted with m_valid & m_ready), pulse done=1 for one cycle, drop busy, return to IDLE.
- Back-to-back start in the same cycle as done is legal and accepted.
- start in RUN or DRAIN is ignored; latched parameters are unchanged.
- Throughput: with m_ready held high, one word per cycle sustained.
- Latency: start to first m_valid is 3 cycles:
  - cycle 1: latch;
  - cycle 2: issue;
  - cycle 3: FIFO push, m_valid seen.
- FIFO rules:
  - Push and pop in the same cycle are allowed, including when the FIFO is full, because of the reservation rule.
  - m_valid = !empty. m_data is stable while m_valid=1 and m_ready=0.
  - Overflow is impossible by construction; the bench asserts it never happens.
- Counters issued and popped are AW+1 bits wide so that len=4096 is representable.

Decomposition:
- Shared package acc_sram_pkg holds:
  - state encoding ST_IDLE / ST_RUN / ST_DRAIN;
  - SRAM_DW, SRAM_MW, SRAM_AW defaults (64/8/12), shared with sram_top instantiations.
- One sub-module: sync_fifo, a parameterised DW x FD FIFO with push, pop, full, empty and count outputs, reusable by the write-side stage.

Test Plan:
- Basic burst: preload addr 0x010..0x017 with data 0x1000+addr; start base=0x010, len=8, m_ready=1.
  - Required: 8 words 0x1010..0x1017 in order, one per cycle from cycle 3;
  - done pulses once, the cycle after the 8th handshake;
  - sram_cs is high for exactly 8 cycles.
- Backpressure: same burst with m_ready toggling 1,0,0,1 repeatedly.
  - Required: identical data sequence, no loss or duplication;
  - m_data stable during stalls; FIFO count never exceeds 4.
- Wrap-around: base=0xFFE, len=4.
  - Required: sram_addr sequence 0xFFE, 0xFFF, 0x000, 0x001; data matches preload.
- Zero and maximum length:
  - len=0: done the next cycle, busy never set, no cs.
  - len=4096 with m_ready=1: 4096 words, done after the last.
- Start while busy: second start at cycle 5 of a len=8 burst with different base.
  - Required: it is ignored and the output is unchanged.
  - A start coincident with done is accepted and runs the new burst.
- Reset mid-burst: assert rst after the 3rd output word.
  - Required: m_valid=0, busy=0, sram_cs=0 immediately; no done pulse.
  - A fresh burst after rst deassertion runs correctly.
